// File: rtl/mem_moc_unit_pkg.sv
// Shared definitions for the MFA/MOC memory: access size codes, FSM states
// and the alignment rule used by the lane aligner.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RW_READ = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  // The reserved size code 2'b11 falls into the word branch.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_moc_unit_if.sv
// Control-unit side bus of the memory: MFA/RW/size strobes, MAR/MDR data,
// and MOC/addr_err completion back to the control unit.
interface mem_moc_unit_if;

  logic        mfa;
  logic        rw;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        addr_err;

  modport master (
    output mfa, rw, size, sign_ext, address, data_in,
    input  data_out, moc, addr_err
  );

  modport slave (
    input  mfa, rw, size, sign_ext, address, data_in,
    output data_out, moc, addr_err
  );

endinterface

// File: rtl/mem_moc_unit_lane_align.sv
// Combinational big-endian lane steering: picks/extends read bytes from an
// aligned word, and builds write byte lanes, byte enables and the misalign flag.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]       size_i,
  input  logic             sign_ext_i,
  input  logic [1:0]       off_i,
  input  logic [3:0][7:0]  raw_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic [3:0][7:0]  wbyte_o,
  output logic [3:0]       be_o,
  output logic             misalign_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Lane index equals the byte offset inside the word, so lane 0 is the MSB.
  always_comb begin
    rdata_o    = '0;
    wbyte_o    = {4{wdata_i[7:0]}};
    be_o       = '0;
    byteSel    = raw_i[off_i];
    halfSel    = {raw_i[{off_i[1], 1'b0}], raw_i[{off_i[1], 1'b1}]};
    misalign_o = misaligned(size_i, off_i);

    case (size_i)
      SZ_BYTE: begin
        rdata_o      = {{24{sign_ext_i & byteSel[7]}}, byteSel};
        be_o[off_i]  = 1'b1;
      end
      SZ_HALF: begin
        rdata_o                  = {{16{sign_ext_i & halfSel[15]}}, halfSel};
        wbyte_o                  = {wdata_i[7:0], wdata_i[15:8], wdata_i[7:0], wdata_i[15:8]};
        be_o[{off_i[1], 1'b0}]   = 1'b1;
        be_o[{off_i[1], 1'b1}]   = 1'b1;
      end
      default: begin
        rdata_o = {raw_i[0], raw_i[1], raw_i[2], raw_i[3]};
        wbyte_o = {wdata_i[7:0], wdata_i[15:8], wdata_i[23:16], wdata_i[31:24]};
        be_o    = 4'hF;
      end
    endcase

    if (misalign_o) begin
      be_o = '0;
    end
  end

endmodule

// File: rtl/mem_moc_unit.sv
// Byte-addressable memory with MFA/MOC handshake and fixed access latency.
// The array starts zeroed; INIT_FILE is kept as a parameter for interface compatibility.
module mem_moc_unit
  import mem_pkg::*;
#(
  parameter int    ADDR_W    = 9,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = "mem_init.hex"
) (
  input  logic clk,
  input  logic reset,
  mem_moc_unit_if.slave mem_if
);

  localparam int         Depth   = 2 ** ADDR_W;
  localparam logic [3:0] LatLoad = 4'(LATENCY - 1);

  logic [7:0] mem_q [Depth] = '{default: 8'h00};

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       dout_q, dout_d;
  logic              moc_q, moc_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] wordBase;
  logic [3:0][7:0]   rawWord;
  logic [31:0]       rdata;
  logic [3:0][7:0]   wbyte;
  logic [3:0]        be;
  logic              misalign;
  logic              accessWe;
  logic              memWe;

  assign wordBase = {addr_q[ADDR_W-1:2], 2'b00};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rawWord[i] = mem_q[wordBase + ADDR_W'(i)];
    end
  end

  mem_lane_align u_lane_align (
    .size_i     (size_q),
    .sign_ext_i (sext_q),
    .off_i      (addr_q[1:0]),
    .raw_i      (rawWord),
    .wdata_i    (wdata_q),
    .rdata_o    (rdata),
    .wbyte_o    (wbyte),
    .be_o       (be),
    .misalign_o (misalign)
  );

  // Request fields are captured only in IDLE so later bus changes cannot disturb an access.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    size_d   = size_q;
    sext_d   = sext_q;
    wdata_d  = wdata_q;
    dout_d   = dout_q;
    moc_d    = moc_q;
    err_d    = err_q;
    accessWe = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_if.mfa) begin
          addr_d  = mem_if.address[ADDR_W-1:0];
          rw_d    = mem_if.rw;
          size_d  = mem_if.size;
          sext_d  = mem_if.sign_ext;
          wdata_d = mem_if.data_in;
          cnt_d   = LatLoad;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          moc_d   = 1'b1;
          err_d   = misalign;
          state_d = DONE;
          if (!misalign) begin
            if (rw_q == RW_READ) begin
              dout_d = rdata;
            end else begin
              accessWe = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (!mem_if.mfa) begin
          moc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign memWe = accessWe & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= RW_READ;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
    end
  end

  // The array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[wordBase + ADDR_W'(i)] <= wbyte[i];
        end
      end
    end
  end

  assign mem_if.data_out = dout_q;
  assign mem_if.moc      = moc_q;
  assign mem_if.addr_err = err_q;

endmodule

// File: tb/tb_mem_moc_unit.sv
// Scoreboard bench for mem_moc_unit: a byte-array reference model predicts each
// completion, and a monitor compares data_out/addr_err whenever moc rises.
module tb_mem_moc_unit;

  localparam int AW    = 9;
  localparam int LAT   = 2;
  localparam int DEPTH = 2 ** AW;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_moc_unit_if mif ();

  mem_moc_unit #(
    .ADDR_W    (AW),
    .LATENCY   (LAT),
    .INIT_FILE ("mem_init.hex")
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .mem_if (mif)
  );

  exp_t        expQ[$];
  int          checks   = 0;
  int          failures = 0;
  byte unsigned refMem [DEPTH];
  logic [31:0] lastRead;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: big-endian byte array, alignment = address multiple of access size.
  function automatic exp_t modelAccess(input bit isRead, input int sz, input bit sx,
                                       input logic [31:0] a, input logic [31:0] d);
    exp_t   e;
    int     base;
    int     nBytes;
    longint v;
    base   = int'(a % DEPTH);
    nBytes = (sz == 0) ? 1 : ((sz == 1) ? 2 : 4);
    e.err  = (base % nBytes) != 0;
    if (!e.err) begin
      if (isRead) begin
        v = 0;
        for (int i = 0; i < nBytes; i++) v = v * 256 + longint'(refMem[base + i]);
        if (sx && nBytes < 4 && v >= (longint'(1) << (8 * nBytes - 1)))
          v = v - (longint'(1) << (8 * nBytes));
        lastRead = v[31:0];
      end else begin
        for (int i = 0; i < nBytes; i++)
          refMem[base + i] = byte'((d >> (8 * (nBytes - 1 - i))) & 32'hFF);
      end
    end
    e.data = lastRead;
    return e;
  endfunction

  // Monitor: one scoreboard entry per rising edge of moc.
  initial begin
    logic mocPrev;
    exp_t e;
    mocPrev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        mocPrev = 1'b0;
      end else begin
        if (mif.moc && !mocPrev) begin
          if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_moc actual=moc_rise required=no_completion data_out=%h", mif.data_out);
          end else begin
            e = expQ.pop_front();
            checkOutput("data_out", mif.data_out, e.data);
            checkOutput("addr_err", 32'(mif.addr_err), 32'(e.err));
          end
        end
        mocPrev = mif.moc;
      end
    end
  end

  // Issues one request; inputs are scrambled right after acceptance to prove latching.
  task automatic applyStimulus(input bit isRead, input logic [1:0] sz, input bit sx,
                               input logic [31:0] a, input logic [31:0] d,
                               input int hold, input bit earlyDrop);
    int cyc;
    @(negedge clk);
    mif.rw       = isRead;
    mif.size     = sz;
    mif.sign_ext = sx;
    mif.address  = a;
    mif.data_in  = d;
    mif.mfa      = 1'b1;
    expQ.push_back(modelAccess(isRead, int'(sz), sx, a, d));
    @(posedge clk);
    @(negedge clk);
    mif.address  = $urandom;
    mif.data_in  = $urandom;
    mif.rw       = ~isRead;
    mif.size     = 2'($urandom_range(0, 3));
    mif.sign_ext = ~sx;
    if (earlyDrop) mif.mfa = 1'b0;
    cyc = 0;
    while (!mif.moc && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    checkOutput("moc_latency", 32'(cyc), 32'(LAT));
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("moc_held", 32'(mif.moc), 32'd1);
    end
    mif.mfa = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("moc_release", 32'(mif.moc), 32'd0);
    checkOutput("addr_err_release", 32'(mif.addr_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lowAddr;
    int   hold;
    logic [31:0] addr;

    for (int i = 0; i < DEPTH; i++) refMem[i] = 8'h00;
    lastRead     = 32'h0;
    reset        = 1'b1;
    mif.mfa      = 1'b0;
    mif.rw       = 1'b1;
    mif.size     = 2'b00;
    mif.sign_ext = 1'b0;
    mif.address  = 32'h0;
    mif.data_in  = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_moc", 32'(mif.moc), 32'd0);
    checkOutput("reset_addr_err", 32'(mif.addr_err), 32'd0);
    checkOutput("reset_data_out", mif.data_out, 32'h0);
    reset = 1'b0;

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h010, 32'h0, 1, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h010 + 32'(i), 32'h0, 0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b1, 32'h012, 32'h0, 0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h012, 32'h0, 0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h011, 32'hFFFFFF55, 0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h010, 32'h0, 0, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h012, 32'h12345678, 0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b1, 32'h011, 32'h0, 0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'hFFFFF010, 32'h0, 5, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h1FC, 32'hA5C3_0F96, 0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h1FC, 32'h0, 2, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b1, 32'h1FD, 32'h0, 0, 1'b1);

    // Reset during BUSY must abort the pending write and clear data_out.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h020, 32'h11223344, 0, 1'b0);
    @(negedge clk);
    mif.rw      = 1'b0;
    mif.size    = 2'b10;
    mif.address = 32'h020;
    mif.data_in = 32'hCAFEF00D;
    mif.mfa     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mif.mfa = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_moc", 32'(mif.moc), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_data_out", mif.data_out, 32'h0);
    reset    = 1'b0;
    lastRead = 32'h0;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h020, 32'h0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      lowAddr = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 63)) : int'($urandom_range(448, 511));
      addr    = ($urandom & 32'hFFFF_FE00) | 32'(lowAddr);
      hold    = int'($urandom_range(0, 3));
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    addr, $urandom, hold, (hold == 0) && ($urandom_range(0, 3) == 0));
    end

    for (int w = 0; w < 10 && expQ.size() != 0; w++) @(negedge clk);
    checkOutput("scoreboard_drain", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
